sram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the single-port `sram` (AW-bit address, DW-bit data, active-low write enable). It sits between two independent requesters and the SRAM. It accepts at most one access per cycle, drives registered address, write-enable and data onto the SRAM, and returns read data to the port that issued the read. Accepted accesses are fully pipelined, so back-to-back accesses from either port sustain one SRAM access per cycle.

---
 rtl/sram_arbiter.sv | 115 +++++++++++
 tb/tb_sram_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port round-robin arbiter and pipelined access sequencer for a
//            single-port registered-read SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          nRST,

    input  logic          p0_valid,
    input  logic          p0_nWE,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_din,
    output logic          p0_ready,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_dout,

    input  logic          p1_valid,
    input  logic          p1_nWE,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_din,
    output logic          p1_ready,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_dout,

    output logic [AW-1:0] sram_adr,
    output logic          sram_nWE,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    logic          r_prio;
    logic [AW-1:0] r_adr;
    logic          r_nwe;
    logic [DW-1:0] r_din;
    logic          r_s1_rd;
    logic          r_s1_port;
    logic          r_s2_rd;
    logic          r_s2_port;
    logic          r_p0_rvalid;
    logic          r_p1_rvalid;
    logic [DW-1:0] r_p0_dout;
    logic [DW-1:0] r_p1_dout;

    logic          w_go0;
    logic          w_go1;

    // Grant is gated by nRST so nothing can be accepted while reset is held.
    assign p0_ready = nRST & p0_valid & (~p1_valid | ~r_prio);
    assign p1_ready = nRST & p1_valid & (~p0_valid |  r_prio);
    assign w_go0    = p0_valid & p0_ready;
    assign w_go1    = p1_valid & p1_ready;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_prio      <= 1'b0;
            r_adr       <= '0;
            r_nwe       <= 1'b1;
            r_din       <= '0;
            r_s1_rd     <= 1'b0;
            r_s1_port   <= 1'b0;
            r_s2_rd     <= 1'b0;
            r_s2_port   <= 1'b0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_dout   <= '0;
            r_p1_dout   <= '0;
        end else begin
            if (w_go0 | w_go1)
                r_prio <= w_go0;

            if (w_go0) begin
                r_adr <= p0_adr;
                r_nwe <= p0_nWE;
                r_din <= p0_din;
            end else if (w_go1) begin
                r_adr <= p1_adr;
                r_nwe <= p1_nWE;
                r_din <= p1_din;
            end else begin
                r_nwe <= 1'b1;
            end

            // Only reads need a tag: writes never produce a response.
            r_s1_rd   <= (w_go0 & p0_nWE) | (w_go1 & p1_nWE);
            r_s1_port <= w_go1;
            r_s2_rd   <= r_s1_rd;
            r_s2_port <= r_s1_port;

            r_p0_rvalid <= r_s2_rd & ~r_s2_port;
            r_p1_rvalid <= r_s2_rd &  r_s2_port;
            if (r_s2_rd & ~r_s2_port)
                r_p0_dout <= sram_dout;
            if (r_s2_rd & r_s2_port)
                r_p1_dout <= sram_dout;
        end
    end

    assign sram_adr  = r_adr;
    assign sram_nWE  = r_nwe;
    assign sram_din  = r_din;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_dout   = r_p0_dout;
    assign p1_dout   = r_p1_dout;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Scoreboard bench for sram_arbiter with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nRST;
    logic          p0_valid, p0_nWE, p0_ready, p0_rvalid;
    logic [AW-1:0] p0_adr;
    logic [DW-1:0] p0_din, p0_dout;
    logic          p1_valid, p1_nWE, p1_ready, p1_rvalid;
    logic [AW-1:0] p1_adr;
    logic [DW-1:0] p1_din, p1_dout;
    logic [AW-1:0] sram_adr;
    logic          sram_nWE;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read single-port SRAM
    always @(posedge clk) begin
        if (!sram_nWE)
            mem[sram_adr] <= sram_din;
        sram_dout <= mem[sram_adr];
    end

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .nRST(nRST),
        .p0_valid(p0_valid), .p0_nWE(p0_nWE), .p0_adr(p0_adr), .p0_din(p0_din),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_dout(p0_dout),
        .p1_valid(p1_valid), .p1_nWE(p1_nWE), .p1_adr(p1_adr), .p1_din(p1_din),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_dout(p1_dout),
        .sram_adr(sram_adr), .sram_nWE(sram_nWE), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops on every rvalid, checks data and two-cycle latency
    always @(negedge clk) begin
        if (p0_ready && p1_ready) begin
            total++; bad++;
            $display("FAIL both_ready: actual=1 required=0");
        end
        if (p0_rvalid) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL p0_unexpected_rvalid: actual dout=%h required no pulse", p0_dout);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (p0_dout !== e.d || cyc != e.c) begin
                    bad++;
                    $display("FAIL p0_read: actual=%h@%0d required=%h@%0d", p0_dout, cyc, e.d, e.c);
                end
            end
        end
        if (p1_rvalid) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL p1_unexpected_rvalid: actual dout=%h required no pulse", p1_dout);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (p1_dout !== e.d || cyc != e.c) begin
                    bad++;
                    $display("FAIL p1_read: actual=%h@%0d required=%h@%0d", p1_dout, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    // Issue one request; valid is left high so consecutive calls stream.
    task automatic req(input int p, input logic nwe, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] ex, input bit score);
        int   n;
        exp_t e;
        if (p == 0) begin
            p0_valid = 1'b1; p0_nWE = nwe; p0_adr = a; p0_din = d;
        end else begin
            p1_valid = 1'b1; p1_nWE = nwe; p1_adr = a; p1_din = d;
        end
        #0;
        n = 0;
        while (!((p == 0) ? p0_ready : p1_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL accept_timeout: actual=no_ready required=ready port=%0d", p);
            return;
        end
        tick();
        if (nwe && score) begin
            e.d = ex;
            e.c = cyc + 2;
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    initial begin
        logic [AW-1:0] cadr [0:3];
        logic          cgnt [0:3];
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        nRST = 1'b0;
        p0_valid = 1'b1; p0_nWE = 1'b1; p0_adr = '0; p0_din = '0;
        p1_valid = 1'b0; p1_nWE = 1'b1; p1_adr = '0; p1_din = '0;

        // Reset behaviour
        repeat (3) tick();
        check("reset_p0_ready", {31'b0, p0_ready}, 32'd0);
        check("reset_sram_nWE", {31'b0, sram_nWE}, 32'd1);
        check("reset_sram_adr", {26'b0, sram_adr}, 32'd0);
        check("reset_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
        nRST = 1'b1;
        p1_valid = 1'b1;
        #1;
        check("first_grant", {30'b0, p0_ready, p1_ready}, 32'd2);
        idle();
        tick();

        // Single-port write then read
        req(0, 1'b0, 6'd5, 32'hDEADBEEF, '0, 1'b1);
        req(0, 1'b1, 6'd5, '0, 32'hDEADBEEF, 1'b1);
        idle();
        repeat (4) tick();

        // Port 1 streaming writes
        for (int i = 0; i < 24; i++)
            req(1, 1'b0, AW'(i), i * 32'h01010101, '0, 1'b1);
        idle();
        repeat (2) tick();

        // Contention: prio is 0 because port 1 was accepted last
        cadr[0] = 6'd1; cadr[1] = 6'd2; cadr[2] = 6'd1; cadr[3] = 6'd2;
        cgnt[0] = 1'b0; cgnt[1] = 1'b1; cgnt[2] = 1'b0; cgnt[3] = 1'b1;
        p0_valid = 1'b1; p0_nWE = 1'b1; p0_adr = 6'd1;
        p1_valid = 1'b1; p1_nWE = 1'b1; p1_adr = 6'd2;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            #0;
            check("contend_grant", {30'b0, p0_ready, p1_ready}, cgnt[i] ? 32'd1 : 32'd2);
            tick();
            check("contend_adr", {26'b0, sram_adr}, {26'b0, cadr[i]});
            e.c = cyc + 2;
            if (cgnt[i]) begin e.d = 32'h02020202; q1.push_back(e); end
            else         begin e.d = 32'h01010101; q0.push_back(e); end
        end
        idle();
        repeat (4) tick();

        // Port 0 streaming reads
        for (int i = 0; i < 24; i++)
            req(0, 1'b1, AW'(i), '0, i * 32'h01010101, 1'b1);
        idle();
        repeat (4) tick();

        // Boundary address
        req(0, 1'b0, 6'd63, 32'hFFFFFFFF, '0, 1'b1);
        check("boundary_adr", {26'b0, sram_adr}, 32'd63);
        req(0, 1'b1, 6'd63, '0, 32'hFFFFFFFF, 1'b1);
        req(0, 1'b1, 6'd0, '0, 32'h00000000, 1'b1);
        idle();
        repeat (4) tick();

        // Reset mid-stream: in-flight read must never respond
        req(0, 1'b1, 6'd5, '0, '0, 1'b0);
        idle();
        tick();
        nRST = 1'b0;
        #1;
        check("midreset_nWE", {31'b0, sram_nWE}, 32'd1);
        repeat (2) tick();
        check("midreset_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
        nRST = 1'b1;
        p0_valid = 1'b1; p1_valid = 1'b1;
        #1;
        check("midreset_prio", {30'b0, p0_ready, p1_ready}, 32'd2);
        idle();
        repeat (5) tick();

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
